// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny window scanner.
package canny_pkg;

    localparam int unsigned WIN_SIZE = 5;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned BEAT_W   = $clog2(WIN_SIZE * WIN_SIZE);
    localparam int unsigned LANE_W   = $clog2(WIN_SIZE);

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        SHIFT_NONE  = 2'b00,
        SHIFT_RIGHT = 2'b01,
        SHIFT_LEFT  = 2'b10,
        SHIFT_DOWN  = 2'b11
    } shift_dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_INIT,
        ST_EMIT,
        ST_FILL_COL,
        ST_FILL_ROW,
        ST_DONE
    } scan_state_t;

    typedef pixel_t [0:WIN_SIZE-1][0:WIN_SIZE-1] window_t;
    typedef pixel_t [0:WIN_SIZE-1]               pix_line_t;

endpackage

// File: rtl/window_regfile.sv
// 5x5 window registers plus 5-entry staging line; load, stage and shift-commit datapath.
module window_regfile
    import canny_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              load_en,
    input  logic [BEAT_W-1:0] load_idx,
    input  logic              stage_en,
    input  logic [LANE_W-1:0] stage_idx,
    input  logic              commit_en,
    input  shift_dir_t        commit_dir,
    input  pixel_t            pix,
    output window_t           win
);

    pix_line_t stage;
    pix_line_t fresh;

    // Staged line with the in-flight final beat bypassed into its slot
    always_comb begin
        fresh = stage;
        for (int i = 0; i < WIN_SIZE; i++) begin
            if (stage_idx == LANE_W'(i)) fresh[i] = pix;
        end
    end

    // Window and staging storage
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            win   <= '0;
            stage <= '0;
        end else begin
            if (stage_en) begin
                for (int i = 0; i < WIN_SIZE; i++) begin
                    if (stage_idx == LANE_W'(i)) stage[i] <= pix;
                end
            end
            if (load_en) begin
                for (int r = 0; r < WIN_SIZE; r++) begin
                    for (int c = 0; c < WIN_SIZE; c++) begin
                        if (load_idx == BEAT_W'(r * WIN_SIZE + c)) win[r][c] <= pix;
                    end
                end
            end else if (commit_en) begin
                case (commit_dir)
                    SHIFT_RIGHT: begin
                        for (int r = 0; r < WIN_SIZE; r++) begin
                            for (int c = 0; c < WIN_SIZE - 1; c++) win[r][c] <= win[r][c+1];
                            win[r][WIN_SIZE-1] <= fresh[r];
                        end
                    end
                    SHIFT_LEFT: begin
                        for (int r = 0; r < WIN_SIZE; r++) begin
                            for (int c = 1; c < WIN_SIZE; c++) win[r][c] <= win[r][c-1];
                            win[r][0] <= fresh[r];
                        end
                    end
                    SHIFT_DOWN: begin
                        for (int r = 0; r < WIN_SIZE - 1; r++) win[r] <= win[r+1];
                        win[WIN_SIZE-1] <= fresh;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/canny_window_scanner.sv
// Serpentine 5x5 window scanner feeding Canny non-maximal suppression.
// Optional build macro CANNY_SCAN_STATS_EN adds a saturating 16-bit window counter output.
module canny_window_scanner
    import canny_pkg::*;
#(
    parameter int unsigned IMG_W = 16,
    parameter int unsigned IMG_H = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  pixel_t     pix_in,
    input  logic       pix_valid,
    output logic       pix_ready,
    output window_t    five_buffer_out,
    output shift_dir_t shift_dir,
    output logic       window_valid,
    input  logic       window_ready,
    output logic       frame_done
`ifdef CANNY_SCAN_STATS_EN
    ,
    output logic [15:0] win_count
`endif
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    scan_state_t       state, state_nxt;
    logic [BEAT_W-1:0] beat_cnt, beat_nxt;
    logic [RW-1:0]     win_r, win_r_nxt;
    logic [CW-1:0]     win_c, win_c_nxt;
    shift_dir_t        fill_dir, fill_dir_nxt;
    shift_dir_t        shift_dir_nxt;
    logic              pix_ready_nxt, window_valid_nxt, frame_done_nxt;
    logic              load_en, stage_en, commit_en;
    logic              beat_acc, win_hs;
`ifdef CANNY_SCAN_STATS_EN
    logic [15:0]       win_count_nxt;
`endif

    window_regfile u_regfile (
        .clk        (clk),
        .n_rst      (n_rst),
        .load_en    (load_en),
        .load_idx   (beat_cnt),
        .stage_en   (stage_en),
        .stage_idx  (beat_cnt[LANE_W-1:0]),
        .commit_en  (commit_en),
        .commit_dir (fill_dir),
        .pix        (pix_in),
        .win        (five_buffer_out)
    );

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= ST_IDLE;
            beat_cnt     <= '0;
            win_r        <= '0;
            win_c        <= '0;
            fill_dir     <= SHIFT_NONE;
            shift_dir    <= SHIFT_NONE;
            pix_ready    <= 1'b0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
`ifdef CANNY_SCAN_STATS_EN
            win_count    <= '0;
`endif
        end else begin
            state        <= state_nxt;
            beat_cnt     <= beat_nxt;
            win_r        <= win_r_nxt;
            win_c        <= win_c_nxt;
            fill_dir     <= fill_dir_nxt;
            shift_dir    <= shift_dir_nxt;
            pix_ready    <= pix_ready_nxt;
            window_valid <= window_valid_nxt;
            frame_done   <= frame_done_nxt;
`ifdef CANNY_SCAN_STATS_EN
            win_count    <= win_count_nxt;
`endif
        end
    end

    // Next-state, counter updates and datapath strobes
    always_comb begin
        state_nxt     = state;
        beat_nxt      = beat_cnt;
        win_r_nxt     = win_r;
        win_c_nxt     = win_c;
        fill_dir_nxt  = fill_dir;
        shift_dir_nxt = shift_dir;
        load_en       = 1'b0;
        stage_en      = 1'b0;
        commit_en     = 1'b0;
        beat_acc      = pix_valid && pix_ready;
        win_hs        = window_valid && window_ready;
`ifdef CANNY_SCAN_STATS_EN
        win_count_nxt = win_count;
`endif

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD_INIT;
                    beat_nxt  = '0;
                    win_r_nxt = '0;
                    win_c_nxt = '0;
`ifdef CANNY_SCAN_STATS_EN
                    win_count_nxt = '0;
`endif
                end
            end
            ST_LOAD_INIT: begin
                if (beat_acc) begin
                    load_en = 1'b1;
                    if (beat_cnt == BEAT_W'(WIN_SIZE * WIN_SIZE - 1)) begin
                        state_nxt     = ST_EMIT;
                        beat_nxt      = '0;
                        shift_dir_nxt = SHIFT_NONE;
                    end else begin
                        beat_nxt = beat_cnt + BEAT_W'(1);
                    end
                end
            end
            ST_FILL_COL, ST_FILL_ROW: begin
                if (beat_acc) begin
                    stage_en = 1'b1;
                    if (beat_cnt == BEAT_W'(WIN_SIZE - 1)) begin
                        commit_en     = 1'b1;
                        state_nxt     = ST_EMIT;
                        beat_nxt      = '0;
                        shift_dir_nxt = fill_dir;
                        case (fill_dir)
                            SHIFT_RIGHT: win_c_nxt = win_c + CW'(1);
                            SHIFT_LEFT:  win_c_nxt = win_c - CW'(1);
                            default:     win_r_nxt = win_r + RW'(1);
                        endcase
                    end else begin
                        beat_nxt = beat_cnt + BEAT_W'(1);
                    end
                end
            end
            ST_EMIT: begin
                if (win_hs) begin
`ifdef CANNY_SCAN_STATS_EN
                    if (win_count != 16'hFFFF) win_count_nxt = win_count + 16'd1;
`endif
                    if (!win_r[0] && (32'(win_c) + 32'(WIN_SIZE) < 32'(IMG_W))) begin
                        state_nxt    = ST_FILL_COL;
                        fill_dir_nxt = SHIFT_RIGHT;
                    end else if (win_r[0] && (win_c != '0)) begin
                        state_nxt    = ST_FILL_COL;
                        fill_dir_nxt = SHIFT_LEFT;
                    end else if (32'(win_r) + 32'(WIN_SIZE) < 32'(IMG_H)) begin
                        state_nxt    = ST_FILL_ROW;
                        fill_dir_nxt = SHIFT_DOWN;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        pix_ready_nxt    = (state_nxt == ST_LOAD_INIT) || (state_nxt == ST_FILL_COL) ||
                           (state_nxt == ST_FILL_ROW);
        window_valid_nxt = (state_nxt == ST_EMIT);
        frame_done_nxt   = (state_nxt == ST_DONE);
    end

endmodule

// File: tb/tb_canny_window_scanner.sv
// Scoreboard bench for canny_window_scanner: three instances (6x6, 5x5, 9x7).
module tb_canny_window_scanner;
    import canny_pkg::*;

    localparam int NI = 3;

    typedef struct packed {
        window_t    win;
        logic [1:0] dir;
    } exp_t;

    function automatic int unsigned dim_w(int k);
        case (k)
            0:       return 6;
            1:       return 5;
            default: return 9;
        endcase
    endfunction

    function automatic int unsigned dim_h(int k);
        case (k)
            0:       return 6;
            1:       return 5;
            default: return 7;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst;
    logic       start        [NI];
    pixel_t     pix_in       [NI];
    logic       pix_valid    [NI];
    logic       pix_ready    [NI];
    window_t    win_out      [NI];
    shift_dir_t shift_dir    [NI];
    logic       window_valid [NI];
    logic       window_ready [NI];
    logic       frame_done   [NI];
`ifdef CANNY_SCAN_STATS_EN
    logic [15:0] win_count   [NI];
`endif

    for (genvar g = 0; g < NI; g++) begin : g_dut
        canny_window_scanner #(.IMG_W(dim_w(g)), .IMG_H(dim_h(g))) u_dut (
            .clk             (clk),
            .n_rst           (n_rst),
            .start           (start[g]),
            .pix_in          (pix_in[g]),
            .pix_valid       (pix_valid[g]),
            .pix_ready       (pix_ready[g]),
            .five_buffer_out (win_out[g]),
            .shift_dir       (shift_dir[g]),
            .window_valid    (window_valid[g]),
            .window_ready    (window_ready[g]),
            .frame_done      (frame_done[g])
`ifdef CANNY_SCAN_STATS_EN
            ,
            .win_count       (win_count[g])
`endif
        );
    end

    int         n_cmp = 0;
    int         n_fail = 0;
    exp_t       exp_q      [NI][$];
    pixel_t     stim_q     [$];
    int         fd_cnt     [NI];
    int         win_seen   [NI];
    int         rdy_mode   [NI];   // 0 tied high, 1 random, 2 hold 10 cycles on window 2
    int         hold_cnt   [NI];
    logic       prev_stall [NI];
    logic       prev_hs    [NI];
    logic       prev_valid [NI];
    window_t    prev_win   [NI];
    shift_dir_t prev_dir   [NI];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Monitor: pops the scoreboard on each new window and checks hold/drop behaviour
    task automatic monitor_step(int k);
        exp_t e;
        if (!n_rst) begin
            prev_stall[k]   = 1'b0;
            prev_hs[k]      = 1'b0;
            prev_valid[k]   = 1'b0;
            window_ready[k] = 1'b1;
            return;
        end
        if (prev_stall[k])
            chk($sformatf("hold_i%0d", k),
                {window_valid[k], pix_ready[k], shift_dir[k], win_out[k]},
                {1'b1, 1'b0, prev_dir[k], prev_win[k]});
        else if (prev_hs[k])
            chk($sformatf("drop_i%0d", k), window_valid[k], 1'b0);
        if (window_valid[k] && !prev_valid[k]) begin
            win_seen[k]++;
            if (exp_q[k].size() == 0) begin
                chk($sformatf("unexpected_window_i%0d", k), 1, 0);
            end else begin
                e = exp_q[k].pop_front();
                chk($sformatf("window_i%0d_n%0d", k, win_seen[k]), win_out[k], e.win);
                chk($sformatf("dir_i%0d_n%0d", k, win_seen[k]), shift_dir[k], e.dir);
                chk($sformatf("ready_in_emit_i%0d", k), pix_ready[k], 1'b0);
            end
        end
        if (frame_done[k]) fd_cnt[k]++;
        case (rdy_mode[k])
            0: window_ready[k] = 1'b1;
            1: window_ready[k] = 1'($urandom_range(0, 1));
            default: begin
                if (window_valid[k] && win_seen[k] == 2 && hold_cnt[k] < 10) begin
                    window_ready[k] = 1'b0;
                    hold_cnt[k]++;
                end else begin
                    window_ready[k] = 1'b1;
                end
            end
        endcase
        prev_valid[k] = window_valid[k];
        prev_stall[k] = window_valid[k] && !window_ready[k];
        prev_hs[k]    = window_valid[k] && window_ready[k];
        prev_win[k]   = win_out[k];
        prev_dir[k]   = shift_dir[k];
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) monitor_step(k);
    end

    // Reference: windows are image sub-blocks at serpentine positions
    task automatic build_image_frame(int k);
        pixel_t     img [16][16];
        exp_t       e;
        int         r, c, w, h;
        shift_dir_t d;
        w = int'(dim_w(k));
        h = int'(dim_h(k));
        stim_q.delete();
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) img[y][x] = pixel_t'($urandom);
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) stim_q.push_back(img[i][j]);
        r = 0; c = 0; d = SHIFT_NONE;
        while (1) begin
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) e.win[i][j] = img[r+i][c+j];
            e.dir = d;
            exp_q[k].push_back(e);
            if (r % 2 == 0 && c + 5 < w) begin
                c++; d = SHIFT_RIGHT;
                for (int i = 0; i < 5; i++) stim_q.push_back(img[r+i][c+4]);
            end else if (r % 2 == 1 && c > 0) begin
                c--; d = SHIFT_LEFT;
                for (int i = 0; i < 5; i++) stim_q.push_back(img[r+i][c]);
            end else if (r + 5 < h) begin
                r++; d = SHIFT_DOWN;
                for (int j = 0; j < 5; j++) stim_q.push_back(img[r+4][c+j]);
            end else begin
                break;
            end
        end
    endtask

    // Pixels numbered 0..39 on the 6x6 instance: four windows, 00/01/11/10
    task automatic build_numbered();
        exp_t e;
        stim_q.delete();
        for (int i = 0; i < 40; i++) stim_q.push_back(pixel_t'(i));
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) e.win[i][j] = pixel_t'(5 * i + j);
        e.dir = 2'b00; exp_q[0].push_back(e);
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) e.win[i][j] = e.win[i][j+1];
            e.win[i][4] = pixel_t'(25 + i);
        end
        e.dir = 2'b01; exp_q[0].push_back(e);
        for (int i = 0; i < 4; i++) e.win[i] = e.win[i+1];
        for (int j = 0; j < 5; j++) e.win[4][j] = pixel_t'(30 + j);
        e.dir = 2'b11; exp_q[0].push_back(e);
        for (int i = 0; i < 5; i++) begin
            for (int j = 4; j > 0; j--) e.win[i][j] = e.win[i][j-1];
            e.win[i][0] = pixel_t'(35 + i);
        end
        e.dir = 2'b10; exp_q[0].push_back(e);
    endtask

    task automatic drive_beat(int k, pixel_t p, output bit ok);
        bit acc;
        int n = 0;
        pix_in[k]    = p;
        pix_valid[k] = 1'b1;
        do begin
            acc = pix_ready[k];
            @(negedge clk);
            n++;
        end while (!acc && n < 2000);
        ok = acc;
        if (!acc) chk($sformatf("beat_timeout_i%0d", k), 0, 1);
    endtask

    task automatic run_frame(int k, int gap_mode, int stop_after);
        bit ok;
        win_seen[k] = 0;
        hold_cnt[k] = 0;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        for (int i = 0; i < stim_q.size() && i < stop_after; i++) begin
            drive_beat(k, stim_q[i], ok);
            if (!ok) break;
            if (i == 24 || (i > 24 && (i - 24) % 5 == 0))
                chk($sformatf("valid_latency_i%0d_b%0d", k, i), window_valid[k], 1'b1);
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                pix_valid[k] = 1'b0;
                @(negedge clk);
            end
        end
        pix_valid[k] = 1'b0;
    endtask

    task automatic finish_frame(int k, int fd0);
        int n = 0;
        while (fd_cnt[k] == fd0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk($sformatf("frame_done_count_i%0d", k), 256'(fd_cnt[k] - fd0), 256'd1);
        chk($sformatf("scoreboard_empty_i%0d", k), 256'(exp_q[k].size()), 256'd0);
    endtask

    task automatic check_reset_outputs(int k, string tag);
        chk($sformatf("%s_i%0d", tag, k),
            {pix_ready[k], window_valid[k], frame_done[k], shift_dir[k], win_out[k]}, '0);
    endtask

    task automatic check_no_ready(int k, int cycles, string tag);
        int hits = 0;
        for (int i = 0; i < cycles; i++) begin
            if (pix_ready[k]) hits++;
            @(negedge clk);
        end
        chk($sformatf("%s_i%0d", tag, k), 256'(hits), 256'd0);
    endtask

    initial begin
        int fd0;
        n_rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            start[k] = 1'b0; pix_valid[k] = 1'b0; pix_in[k] = '0;
            window_ready[k] = 1'b1; rdy_mode[k] = 0; fd_cnt[k] = 0;
            win_seen[k] = 0; hold_cnt[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) check_reset_outputs(k, "por");
        n_rst = 1'b1;
        check_no_ready(0, 5, "idle_after_por");

        // Numbered 6x6 frame, window_ready tied high
        build_numbered();
        fd0 = fd_cnt[0]; run_frame(0, 0, 1000); finish_frame(0, fd0);

        // Backpressure on window 2
        rdy_mode[0] = 2;
        build_image_frame(0);
        fd0 = fd_cnt[0]; run_frame(0, 0, 1000); finish_frame(0, fd0);
        chk("bp_hold_cycles", 256'(hold_cnt[0]), 256'd10);

        // Gap after every beat
        rdy_mode[0] = 0;
        build_image_frame(0);
        fd0 = fd_cnt[0]; run_frame(0, 1, 1000); finish_frame(0, fd0);

        // Randomized frames on the 9x7 instance
        rdy_mode[2] = 1;
        for (int n = 0; n < 3; n++) begin
            build_image_frame(2);
            fd0 = fd_cnt[2]; run_frame(2, 2, 1000); finish_frame(2, fd0);
        end

        // 5x5: single window then no further pix_ready
        build_image_frame(1);
        fd0 = fd_cnt[1]; run_frame(1, 0, 1000); finish_frame(1, fd0);
        check_no_ready(1, 10, "no_ready_after_5x5");

        // Reset after the 3rd beat of a FILL_COL
        build_numbered();
        run_frame(0, 0, 28);
        n_rst = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) check_reset_outputs(k, "midfill_reset");
        for (int k = 0; k < NI; k++) exp_q[k].delete();
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        check_no_ready(0, 5, "idle_after_reset");

        // Fresh frame after reset
        build_numbered();
        fd0 = fd_cnt[0]; run_frame(0, 0, 1000); finish_frame(0, fd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
